// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - bundle of write-back queue handshake, write-port and forwarding signals
//
// Purpose: groups every non-clock/reset signal of reg_writeback_queue so the
// pipeline top-level wires the execute stage, register file write port and
// read-stage forwarding through one connection.
//
// Signals (direction as seen from the slave, i.e. the queue):
//   in_valid   in   execute stage presents a result
//   in_ready   out  queue accepts a result this cycle
//   in_reg     in   destination register index
//   in_data    in   result value
//   stall_wr   in   register file write port busy; hold the queue head
//   regwrite   out  registered write strobe
//   write_reg  out  registered write index
//   write_data out  registered write value
//   fwd_reg    in   index being read by the decode/read stage
//   fwd_hit    out  a pending write targets fwd_reg
//   fwd_data   out  youngest pending value for fwd_reg
//   count      out  queue occupancy, excluding the output register
//
// Modports: master = execute/read-stage side, slave = the queue.
interface reg_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_W-1:0]        in_reg;
  logic [DATA_W-1:0]        in_data;
  logic                     stall_wr;
  logic                     regwrite;
  logic [ADDR_W-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic [ADDR_W-1:0]        fwd_reg;
  logic                     fwd_hit;
  logic [DATA_W-1:0]        fwd_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_reg, in_data, stall_wr, fwd_reg,
    input  in_ready, regwrite, write_reg, write_data, fwd_hit, fwd_data, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, stall_wr, fwd_reg,
    output in_ready, regwrite, write_reg, write_data, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order write-back queue feeding the 8x8 register file write port
//
// Purpose: buffers destination/result pairs from the execute stage in a small
// circular queue and drains one entry per cycle into registered write-port
// outputs. Optional forwarding of still-pending results to the read stage.
//
// Ports:
//   clk  in  sole clock, rising edge
//   rst  in  synchronous, active-high reset
//   bus  reg_writeback_queue_if.slave (handshake, write port, forwarding, count)
//
// Build option: define REG_WB_FORWARD_EN to build the forwarding comparators
// and priority mux. Without it fwd_hit/fwd_data are tied to 0, fwd_reg is
// ignored, and the read stage must interlock on count != 0 || regwrite.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  reg_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_reg_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // No fall-through when full: a pop in the same cycle does not free a slot
  // until the next cycle, keeping in_ready a function of count and rst only.
  assign w_in_ready = (r_count != CNT_W'(DEPTH)) && !rst;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = (r_count != '0) && !bus.stall_wr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg_mem[r_tail]  <= bus.in_reg;
      r_data_mem[r_tail] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head       <= r_head + 1'b1;
        r_write_reg  <= r_reg_mem[r_head];
        r_write_data <= r_data_mem[r_head];
      end
      r_regwrite <= w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef REG_WB_FORWARD_EN
  // Scan from the output register through the queue oldest to youngest so the
  // last match wins: youngest queue entry beats older ones beats the output.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (r_regwrite && (r_write_reg == bus.fwd_reg)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_write_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) &&
          (r_reg_mem[r_head + PTR_W'(k)] == bus.fwd_reg)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data_mem[r_head + PTR_W'(k)];
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^bus.fwd_reg;
  assign w_fwd_hit    = 1'b0;
  assign w_fwd_data   = '0;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.regwrite   = r_regwrite;
  assign bus.write_reg  = r_write_reg;
  assign bus.write_data = r_write_data;
  assign bus.fwd_hit    = w_fwd_hit;
  assign bus.fwd_data   = w_fwd_data;
  assign bus.count      = r_count;
endmodule
